// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sequencer: FSM encodings, mode values and
// the default iteration geometry used by the firmware build.
package cordic_pkg;

   localparam int CORDIC_ITERATION_WIDTH = 4;
   localparam int CORDIC_MAX_ITERATIONS  = 16;
   localparam int CORDIC_SCALE_CYCLES    = 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_COMPUTE = 3'd2;
   localparam logic [2:0] ST_SCALE   = 3'd3;
   localparam logic [2:0] ST_HOLD    = 3'd4;

   localparam logic MODE_VECTORING = 1'b0;
   localparam logic MODE_ROTATION  = 1'b1;

endpackage

// File: rtl/cordic_step_counter.sv
// Up-counter with synchronous clear and a terminal-count flag; it parks at
// the terminal value instead of wrapping if enable stays high.
module cordic_step_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] last,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   assign tc = (count == last);

   // NOTE: state uses non-blocking assignments and an async active-low reset
   // in the sensitivity list, so reset takes effect without a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en && !tc) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC shift-add datapath: accepts a job, pulses
// load, walks the micro-rotation index, optionally scales, then holds the result.
module cordic_seq_ctrl
   import cordic_pkg::*;
#(
   parameter int ITERATION_WIDTH = CORDIC_ITERATION_WIDTH,
   parameter int MAX_ITERATIONS  = CORDIC_MAX_ITERATIONS,
   parameter int SCALE_CYCLES    = CORDIC_SCALE_CYCLES
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ITERATION_WIDTH-1:0] iter_cfg,
   input  logic                       mode_in,
   input  logic                       abort,
   output logic                       load,
   output logic                       iter_en,
   output logic [ITERATION_WIDTH-1:0] iter_idx,
   output logic                       mode,
   output logic                       scale_en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int IW = ITERATION_WIDTH;
   localparam int SW = (SCALE_CYCLES > 1) ? $clog2(SCALE_CYCLES) : 1;
   localparam logic [IW-1:0] ITER_CAP   = IW'(MAX_ITERATIONS - 1);
   localparam logic [SW-1:0] SCALE_LAST = SW'((SCALE_CYCLES > 0) ? SCALE_CYCLES - 1 : 0);

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [IW-1:0] iter_last;
   logic          mode_q;
   logic          accept;
   logic [IW-1:0] iter_cnt;
   logic          iter_tc;
   logic [SW-1:0] scale_cnt;
   logic          scale_tc;

   assign accept = (state == ST_IDLE) && in_valid && !abort;

   // NOTE: every combinational output gets a default before the case so no
   // path through the block leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (accept) state_nxt = ST_LOAD;
         ST_LOAD:    state_nxt = ST_COMPUTE;
         ST_COMPUTE: if (iter_tc) state_nxt = (SCALE_CYCLES == 0) ? ST_HOLD : ST_SCALE;
         ST_SCALE:   if (scale_tc) state_nxt = ST_HOLD;
         ST_HOLD:    if (out_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         iter_last <= '0;
         mode_q    <= MODE_VECTORING;
      end else begin
         state <= state_nxt;
         if (accept) begin
            // Clamp so the index never passes the last atan-ROM entry.
            iter_last <= (iter_cfg >= ITER_CAP) ? ITER_CAP : iter_cfg;
            mode_q    <= mode_in;
         end
      end
   end

   // Counters are cleared on leaving their state so the next job starts at 0.
   cordic_step_counter #(.WIDTH(IW)) u_iter_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear ((state != ST_COMPUTE) || abort || iter_tc),
      .en    (state == ST_COMPUTE),
      .last  (iter_last),
      .count (iter_cnt),
      .tc    (iter_tc)
   );

   cordic_step_counter #(.WIDTH(SW)) u_scale_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear ((state != ST_SCALE) || abort || scale_tc),
      .en    (state == ST_SCALE),
      .last  (SCALE_LAST),
      .count (scale_cnt),
      .tc    (scale_tc)
   );

   assign in_ready  = (state == ST_IDLE);
   assign load      = (state == ST_LOAD);
   assign iter_en   = (state == ST_COMPUTE);
   assign scale_en  = (state == ST_SCALE);
   assign out_valid = (state == ST_HOLD);
   assign busy      = (state == ST_LOAD) || (state == ST_COMPUTE) ||
                      (state == ST_SCALE) || (state == ST_HOLD);
   assign done      = (state == ST_HOLD) && out_ready && !abort;
   assign iter_idx  = iter_cnt;
   assign mode      = mode_q;

endmodule
